seq_pattern_monitor: RTL and testbench
======================================

Name: seq_pattern_monitor

Overview:
- Downstream checker for the 3-bit sequence counter; consumes its Q output every cycle.
- Verifies the cyclic pattern 000 -> 001 -> 010 -> 111 -> 000.
- Acquires lock, flags illegal codes and broken transitions, and counts completed laps.
- Sits between the counter and the status/debug register block.

Parameters:
S0, 3'b000, first pattern code (lap boundary)
S1, 3'b001, second pattern code
S2, 3'b010, third pattern code
S3, 3'b111, fourth pattern code
LOCK_CNT, 2, consecutive correct transitions required to enter LOCKED (>=1)
LAP_W, 8, width of lap counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
sample_valid  in  1  sample qualifies this cycle; ignored when low
sample  in  3  counter value (Q)
locked  out  1  high while FSM in LOCKED
expected  out  3  predicted next code; 000 when not tracking
illegal_pulse  out  1  one-cycle pulse: accepted sample not in {S0..S3}
err_pulse  out  1  one-cycle pulse: wrong successor seen while TRACK or LOCKED
err_count  out  8  err_pulse count, saturates at 255
lap_pulse  out  1  one-cycle pulse on a locked S3 -> S0 transition
lap_count  out  LAP_W  lap_pulse count, wraps to 0

Behaviour:
- Reset (async): FSM=SEARCH, prev=000, good_cnt=0.
- Reset: locked=0, expected=000, all pulses 0, err_count=0, lap_count=0.
- Reset mid-operation discards all history; counters clear immediately.
- Outputs registered; response appears the cycle after the accepted sample (latency 1).
- Pulses are one cycle wide. With sample_valid low, state holds and pulses deassert.
- succ(x): S0->S1, S1->S2, S2->S3, S3->S0. A sample is legal if it is one of S0..S3.
- SEARCH:
  - Legal sample -> TRACK; prev=sample, good_cnt=0, expected=succ(sample).
  - Illegal sample -> illegal_pulse; stay in SEARCH.
- TRACK:
  - sample==expected -> good_cnt+1, prev=sample.
  - When good_cnt reaches LOCK_CNT -> LOCKED and locked=1 on the same registered edge.
  - Legal mismatch -> err_pulse; restart TRACK from sample (good_cnt=0).
  - Illegal sample -> err_pulse and illegal_pulse together; go to SEARCH.
- LOCKED:
  - sample==expected -> stay in LOCKED.
  - If prev==S3 and sample==S0 -> lap_pulse, lap_count+1.
  - Legal mismatch -> err_pulse; go to TRACK from sample; locked drops.
  - Illegal sample -> err_pulse and illegal_pulse; go to SEARCH.
- A repeated code (sample==prev) is a mismatch, not a stall.
- lap_pulse is never raised outside LOCKED, including on the transition that achieves lock.
- err_count saturates at 8'hFF and holds. lap_count wraps from 2^LAP_W-1 to 0.

Optional Feature:
SEQ_MON_STICKY_EN
- Defined: adds input err_clr (1) and output err_sticky (1).
  - err_sticky sets on any err_pulse or illegal_pulse and holds until err_clr.
  - err_clr also zeroes err_count in the same cycle.
  - If err_clr coincides with a new error, set wins: err_sticky=1, err_count=1.
  - Reset clears err_sticky.
- Undefined: neither port exists; err_count clears only on rst.

Test Plan:
- Reset then feed 000,001,010,111,000,001 every cycle, LOCK_CNT=2:
  - locked=1 the cycle after 010.
  - lap_pulse once, after the 000 that follows 111.
  - err_count=0.
- Locked stream with 011 injected in place of 010:
  - err_pulse=1 and illegal_pulse=1 in the same cycle.
  - locked=0, FSM in SEARCH, err_count=1.
  - Relock after two further correct transitions.
- Locked stream with sample_valid low for 5 cycles between 001 and 010:
  - No pulses; locked stays 1.
  - expected=010 throughout.
- Repeat 001,001 while locked:
  - err_pulse, locked=0, restart TRACK.
  - expected=010.
- Force 300 errors, then run 2^LAP_W+1 laps, LAP_W=8:
  - err_count holds 255.
  - lap_count wraps through 0 and ends at 1.
- Assert rst mid-lap while locked:
  - All outputs 0 immediately, before the next clock edge.
  - With SEQ_MON_STICKY_EN, err_sticky clears; err_clr coincident with an error leaves err_sticky=1 and err_count=1.

Source files
------------

// File: rtl/seq_pattern_monitor.sv
// seq_pattern_monitor: locks onto the 000->001->010->111 cycle, flags illegal codes and broken steps, counts laps.
// Optional SEQ_MON_STICKY_EN adds err_clr/err_sticky.
module seq_pattern_monitor #(
  parameter logic [2:0] S0 = 3'b000,
  parameter logic [2:0] S1 = 3'b001,
  parameter logic [2:0] S2 = 3'b010,
  parameter logic [2:0] S3 = 3'b111,
  parameter int LOCK_CNT = 2,
  parameter int LAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [2:0]       sample,
`ifdef SEQ_MON_STICKY_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic             locked,
  output logic [2:0]       expected,
  output logic             illegal_pulse,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic             lap_pulse,
  output logic [LAP_W-1:0] lap_count
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] LC = GW'(LOCK_CNT);
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  logic [1:0]    r_st, w_st_n;
  logic [2:0]    r_prev, w_prev_n, r_exp, w_exp_n;
  logic [GW-1:0] r_gc, w_gc_n, w_gc_inc;
  logic          w_ill, w_err, w_lap, w_legal, w_trk;
  logic [7:0]    w_errc_n;
  function automatic logic [2:0] succ(input logic [2:0] x);
    return x == S0 ? S1 : x == S1 ? S2 : x == S2 ? S3 : S0;
  endfunction
  assign w_legal  = sample == S0 || sample == S1 || sample == S2 || sample == S3;
  assign w_trk    = r_st != ST_SEARCH;
  assign w_gc_inc = r_gc + GW'(1);
  always_comb begin
    w_st_n   = r_st;
    w_prev_n = r_prev;
    w_gc_n   = r_gc;
    w_exp_n  = r_exp;
    w_ill    = 1'b0;
    w_err    = 1'b0;
    w_lap    = 1'b0;
    if (sample_valid) begin
      if (!w_legal) begin
        w_ill    = 1'b1;
        w_err    = w_trk;
        w_st_n   = ST_SEARCH;
        w_prev_n = 3'b000;
        w_gc_n   = '0;
        w_exp_n  = 3'b000;
      end else if (w_trk && sample == r_exp) begin
        w_prev_n = sample;
        w_exp_n  = succ(sample);
        w_lap    = r_st == ST_LOCKED && r_prev == S3 && sample == S0;
        if (r_st == ST_TRACK) begin
          w_gc_n = w_gc_inc;
          w_st_n = w_gc_inc == LC ? ST_LOCKED : ST_TRACK;
        end
      end else begin
        // any legal code that is not the predicted successor restarts tracking from it
        w_err    = w_trk;
        w_st_n   = ST_TRACK;
        w_prev_n = sample;
        w_gc_n   = '0;
        w_exp_n  = succ(sample);
      end
    end
  end
`ifdef SEQ_MON_STICKY_EN
  assign w_errc_n = w_err ? (err_clr ? 8'd1 : err_count == 8'hFF ? err_count : err_count + 8'd1)
                          : (err_clr ? 8'd0 : err_count);
  always_ff @(posedge clk or posedge rst)
    if (rst) err_sticky <= 1'b0;
    else     err_sticky <= (w_err || w_ill) ? 1'b1 : err_clr ? 1'b0 : err_sticky;
`else
  assign w_errc_n = w_err && err_count != 8'hFF ? err_count + 8'd1 : err_count;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st          <= ST_SEARCH;
      r_prev        <= 3'b000;
      r_gc          <= '0;
      r_exp         <= 3'b000;
      illegal_pulse <= 1'b0;
      err_pulse     <= 1'b0;
      lap_pulse     <= 1'b0;
      err_count     <= 8'd0;
      lap_count     <= '0;
    end else begin
      r_st          <= w_st_n;
      r_prev        <= w_prev_n;
      r_gc          <= w_gc_n;
      r_exp         <= w_exp_n;
      illegal_pulse <= w_ill;
      err_pulse     <= w_err;
      lap_pulse     <= w_lap;
      err_count     <= w_errc_n;
      lap_count     <= w_lap ? lap_count + LAP_W'(1) : lap_count;
    end
  end
  assign locked   = r_st == ST_LOCKED;
  assign expected = r_exp;
endmodule

// File: tb/tb_seq_pattern_monitor.sv
// tb_seq_pattern_monitor: directed vectors for seq_pattern_monitor (LOCK_CNT=2, LAP_W=8).
// Status word checked each step is {locked, expected, illegal_pulse, err_pulse, lap_pulse}.
module tb_seq_pattern_monitor;
  logic       clk = 1'b0, rst = 1'b1, sample_valid = 1'b0;
  logic [2:0] sample = 3'b000;
  logic       locked, illegal_pulse, err_pulse, lap_pulse;
  logic [2:0] expected;
  logic [7:0] err_count, lap_count;
  int n_vec = 0, n_err = 0;
`ifdef SEQ_MON_STICKY_EN
  logic err_clr = 1'b0, err_sticky;
`endif
  seq_pattern_monitor dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
`ifdef SEQ_MON_STICKY_EN
    .err_clr(err_clr), .err_sticky(err_sticky),
`endif
    .locked(locked), .expected(expected), .illegal_pulse(illegal_pulse),
    .err_pulse(err_pulse), .err_count(err_count), .lap_pulse(lap_pulse), .lap_count(lap_count)
  );
  wire [6:0] stat = {locked, expected, illegal_pulse, err_pulse, lap_pulse};
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [2:0] s);
    sample_valid = v;
    sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    n_vec++; if (stat !== 7'b0) begin n_err++; $display("FAIL reset_stat got %b want %b", stat, 7'b0); end
    n_vec++; if (err_count !== 8'd0 || lap_count !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", err_count, lap_count); end
    rst = 1'b0;
  endtask

  task automatic test_lock;
    logic [2:0] smp [6] = '{3'b000, 3'b001, 3'b010, 3'b111, 3'b000, 3'b001};
    logic [6:0] exp_st [6] = '{7'b0001000, 7'b0010000, 7'b1111000, 7'b1000000, 7'b1001001, 7'b1010000};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, smp[i]);
      n_vec++; if (stat !== exp_st[i]) begin n_err++; $display("FAIL lock_step%0d got %b want %b", i, stat, exp_st[i]); end
    end
    n_vec++; if (err_count !== 8'd0 || lap_count !== 8'd1) begin n_err++; $display("FAIL lock_cnt got err=%0d lap=%0d want 0/1", err_count, lap_count); end
  endtask

  task automatic test_illegal;
    step(1'b1, 3'b011);
    n_vec++; if (stat !== 7'b0000110) begin n_err++; $display("FAIL illegal_stat got %b want %b", stat, 7'b0000110); end
    n_vec++; if (err_count !== 8'd1) begin n_err++; $display("FAIL illegal_errc got %0d want 1", err_count); end
    step(1'b1, 3'b111);
    n_vec++; if (stat !== 7'b0000000) begin n_err++; $display("FAIL relock0 got %b want %b", stat, 7'b0000000); end
    step(1'b1, 3'b000);
    n_vec++; if (stat !== 7'b0001000) begin n_err++; $display("FAIL relock1 got %b want %b", stat, 7'b0001000); end
    step(1'b1, 3'b001);
    n_vec++; if (stat !== 7'b1010000) begin n_err++; $display("FAIL relock2 got %b want %b", stat, 7'b1010000); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'b101);
      n_vec++; if (stat !== 7'b1010000) begin n_err++; $display("FAIL stall%0d got %b want %b", i, stat, 7'b1010000); end
    end
    step(1'b1, 3'b010);
    n_vec++; if (stat !== 7'b1111000) begin n_err++; $display("FAIL stall_resume got %b want %b", stat, 7'b1111000); end
  endtask

  task automatic test_repeat;
    step(1'b1, 3'b111);
    step(1'b1, 3'b000);
    n_vec++; if (stat !== 7'b1001001 || lap_count !== 8'd2) begin n_err++; $display("FAIL rep_lap got %b/%0d want %b/2", stat, lap_count, 7'b1001001); end
    step(1'b1, 3'b001);
    step(1'b1, 3'b001);
    n_vec++; if (stat !== 7'b0010010) begin n_err++; $display("FAIL rep_err got %b want %b", stat, 7'b0010010); end
    n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL rep_errc got %0d want 2", err_count); end
    step(1'b1, 3'b010);
    n_vec++; if (stat !== 7'b0111000) begin n_err++; $display("FAIL rep_trk got %b want %b", stat, 7'b0111000); end
    step(1'b1, 3'b111);
    n_vec++; if (stat !== 7'b1000000) begin n_err++; $display("FAIL rep_relock got %b want %b", stat, 7'b1000000); end
  endtask

  task automatic test_saturate_wrap;
    logic [2:0] lap_seq [4] = '{3'b001, 3'b010, 3'b111, 3'b000};
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step(1'b1, 3'b000);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 3'b000);
      n_vec++; if (stat !== 7'b0001010) begin n_err++; $display("FAIL sat_err%0d got %b want %b", i, stat, 7'b0001010); end
    end
    n_vec++; if (err_count !== 8'hFF) begin n_err++; $display("FAIL sat_errc got %0d want 255", err_count); end
    for (int k = 1; k <= 257; k++) begin
      for (int j = 0; j < 4; j++) step(1'b1, lap_seq[j]);
      n_vec++; if (stat !== 7'b1001001 || lap_count !== 8'(k)) begin n_err++; $display("FAIL lap%0d got %b/%0d want %b/%0d", k, stat, lap_count, 7'b1001001, k % 256); end
    end
    n_vec++; if (err_count !== 8'hFF || lap_count !== 8'd1) begin n_err++; $display("FAIL wrap_end got err=%0d lap=%0d want 255/1", err_count, lap_count); end
  endtask

  task automatic test_async_reset;
    step(1'b1, 3'b001);
    n_vec++; if (stat !== 7'b1010000) begin n_err++; $display("FAIL pre_rst got %b want %b", stat, 7'b1010000); end
    #3 rst = 1'b1;
    #1;
    n_vec++; if (stat !== 7'b0 || err_count !== 8'd0 || lap_count !== 8'd0) begin n_err++; $display("FAIL async_rst got %b/%0d/%0d want 0/0/0", stat, err_count, lap_count); end
    step(1'b0, 3'b000);
    rst = 1'b0;
  endtask

`ifdef SEQ_MON_STICKY_EN
  task automatic test_sticky;
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_rst got %b want 0", err_sticky); end
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    n_vec++; if (err_sticky !== 1'b1 || err_count !== 8'd1) begin n_err++; $display("FAIL sticky_set got %b/%0d want 1/1", err_sticky, err_count); end
    err_clr = 1'b1;
    step(1'b0, 3'b000);
    n_vec++; if (err_sticky !== 1'b0 || err_count !== 8'd0) begin n_err++; $display("FAIL sticky_clr got %b/%0d want 0/0", err_sticky, err_count); end
    step(1'b1, 3'b000);
    err_clr = 1'b0;
    n_vec++; if (err_sticky !== 1'b1 || err_count !== 8'd1) begin n_err++; $display("FAIL sticky_setwins got %b/%0d want 1/1", err_sticky, err_count); end
    #3 rst = 1'b1;
    #1;
    n_vec++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_async got %b want 0", err_sticky); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_illegal();
    test_stall();
    test_repeat();
    test_saturate_wrap();
    test_async_reset();
`ifdef SEQ_MON_STICKY_EN
    test_sticky();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
